// File: rtl/rr_arbiter16_pkg.sv
// Shared definitions for the 16-requester round-robin arbiter:
// FSM state encoding and requester/index sizing.
package arb_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter16_if.sv
// Request/grant bundle between the clients and the arbiter.
// The master side drives requests and done; the slave side (the arbiter)
// drives the grant outputs.
interface rr_arbiter16_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             timeout;

    modport master (
        output req, done,
        input  gnt, gnt_idx, gnt_valid, timeout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_idx, gnt_valid, timeout
    );

endinterface

// File: rtl/rr_arbiter16_dec4.sv
// 4-to-16 one-hot decoder. The select bus is numbered MSB-first:
// sel[0] is the most significant bit of the decoded index.
module rr_dec4
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0] sel,
    output logic [N_REQ-1:0] onehot
);

    logic [IDX_W-1:0] code;

    assign code = {sel[0], sel[1], sel[2], sel[3]};

    // Set exactly the one output bit addressed by the reordered select.
    always_comb begin
        onehot       = '0;
        onehot[code] = 1'b1;
    end

endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter for 16 clients with grant hold, done handshake and a
// hold-timeout watchdog. A release always costs one dead cycle before the
// next grant, and the search restarts just past the last grantee.
module rr_arbiter16
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 8
)(
    input  logic          clk,
    input  logic          rst,
    rr_arbiter16_if.slave bus
);

    localparam bit              HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic [CNT_W-1:0] hold_cnt;
    logic             gnt_valid;
    logic             timeout;

    logic             found;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] rev_idx;
    logic [N_REQ-1:0] dec_out;

    // Rotating priority search: first requester at or after ptr, wrapping at 16.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        cand   = ptr;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!found && bus.req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Arbiter FSM: arbitrate in IDLE/RELEASE, hold and watch for release in GRANT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE, RELEASE: begin
                    if (found) begin
                        gnt_idx   <= winner;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                        state     <= GRANT;
                    end else begin
                        gnt_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                GRANT: begin
                    if (bus.done || !bus.req[gnt_idx]) begin
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_idx + IDX_W'(1);
                        state     <= RELEASE;
                    end else if (HOLD_EN && (hold_cnt == HOLD_LAST)) begin
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_idx + IDX_W'(1);
                        timeout   <= 1'b1;
                        state     <= RELEASE;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    gnt_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // The decoder numbers its select MSB-first, so feed it the reversed index.
    assign rev_idx = {gnt_idx[0], gnt_idx[1], gnt_idx[2], gnt_idx[3]};

    rr_dec4 u_dec (
        .sel    (rev_idx),
        .onehot (dec_out)
    );

    assign bus.gnt       = dec_out & {N_REQ{gnt_valid}};
    assign bus.gnt_idx   = gnt_idx;
    assign bus.gnt_valid = gnt_valid;
    assign bus.timeout   = timeout;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Bench for rr_arbiter16: two instances (MAX_HOLD=15 and MAX_HOLD=4) share
// the same stimulus and are each compared every cycle against a behavioural
// model, plus a directed vector table and hand-written corner sequences.
module tb_rr_arbiter16;
    import arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] reqDrv = '0;
    logic        doneDrv = 1'b0;

    rr_arbiter16_if ifA ();
    rr_arbiter16_if ifB ();

    assign ifA.req  = reqDrv;
    assign ifA.done = doneDrv;
    assign ifB.req  = reqDrv;
    assign ifB.done = doneDrv;

    rr_arbiter16 #(.MAX_HOLD(15), .CNT_W(8)) dutA (.clk(clk), .rst(rst), .bus(ifA.slave));
    rr_arbiter16 #(.MAX_HOLD(4),  .CNT_W(8)) dutB (.clk(clk), .rst(rst), .bus(ifB.slave));

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: who owns the resource and for how many visible cycles so far.
    typedef struct {
        bit active;
        int owner;
        int held;
        int ptr;
        bit to;
    } mstate_t;

    mstate_t mA, mB;

    typedef struct {
        logic [15:0] req;
        logic        done;
        logic        rst;
        logic [15:0] gnt;
        logic [3:0]  idx;
        logic        valid;
        logic        to;
    } vec_t;

    vec_t vecs[13];

    function automatic mstate_t stepModel(mstate_t m, logic [15:0] r, logic d, logic rs, int maxHold);
        mstate_t n;
        bit      hit;
        n    = m;
        n.to = 1'b0;
        if (rs) begin
            n.active = 1'b0;
            n.owner  = 0;
            n.held   = 0;
            n.ptr    = 0;
        end else if (m.active) begin
            if (d || !r[m.owner]) begin
                n.active = 1'b0;
                n.ptr    = (m.owner + 1) % 16;
            end else if (maxHold != 0 && m.held == maxHold) begin
                n.active = 1'b0;
                n.ptr    = (m.owner + 1) % 16;
                n.to     = 1'b1;
            end else begin
                n.held = m.held + 1;
            end
        end else begin
            hit = 1'b0;
            for (int i = 0; i < 16; i++) begin
                int k;
                k = (m.ptr + i) % 16;
                if (!hit && r[k]) begin
                    hit      = 1'b1;
                    n.active = 1'b1;
                    n.owner  = k;
                    n.held   = 1;
                end
            end
        end
        return n;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        check("A.gnt",     32'(ifA.gnt),       mA.active ? (32'd1 << mA.owner) : 32'd0);
        check("A.gnt_idx", 32'(ifA.gnt_idx),   32'(mA.owner));
        check("A.valid",   32'(ifA.gnt_valid), 32'(mA.active));
        check("A.timeout", 32'(ifA.timeout),   32'(mA.to));
        check("B.gnt",     32'(ifB.gnt),       mB.active ? (32'd1 << mB.owner) : 32'd0);
        check("B.gnt_idx", 32'(ifB.gnt_idx),   32'(mB.owner));
        check("B.valid",   32'(ifB.gnt_valid), 32'(mB.active));
        check("B.timeout", 32'(ifB.timeout),   32'(mB.to));
    endtask

    task automatic applyStimulus(logic [15:0] r, logic d, logic rs);
        @(negedge clk);
        reqDrv  = r;
        doneDrv = d;
        rst     = rs;
        @(posedge clk);
        mA = stepModel(mA, r, d, rs, 15);
        mB = stepModel(mB, r, d, rs, 4);
        #1;
        checkOutput();
    endtask

    initial begin
        int          cnt;
        int          guard;
        logic [15:0] r;
        logic        d;
        logic        rs;

        mA = '{default: 0};
        mB = '{default: 0};

        // Reset, idle, single-client grant with done, pointer advance, withdraw.
        vecs[0]  = '{16'h0000, 1'b0, 1'b1, 16'h0000, 4'd0, 1'b0, 1'b0};
        vecs[1]  = '{16'h0000, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0};
        vecs[2]  = '{16'h0000, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0};
        vecs[3]  = '{16'h0000, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0};
        vecs[4]  = '{16'h0000, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0};
        vecs[5]  = '{16'h0000, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0};
        vecs[6]  = '{16'h0001, 1'b0, 1'b0, 16'h0001, 4'd0, 1'b1, 1'b0};
        vecs[7]  = '{16'h0001, 1'b0, 1'b0, 16'h0001, 4'd0, 1'b1, 1'b0};
        vecs[8]  = '{16'h0001, 1'b0, 1'b0, 16'h0001, 4'd0, 1'b1, 1'b0};
        vecs[9]  = '{16'h0001, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0};
        vecs[10] = '{16'h0003, 1'b0, 1'b0, 16'h0002, 4'd1, 1'b1, 1'b0};
        vecs[11] = '{16'h0000, 1'b0, 1'b0, 16'h0000, 4'd1, 1'b0, 1'b0};
        vecs[12] = '{16'h0000, 1'b1, 1'b0, 16'h0000, 4'd1, 1'b0, 1'b0};

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].req, vecs[i].done, vecs[i].rst);
            check($sformatf("vec%0d.gnt", i),   32'(ifA.gnt),       32'(vecs[i].gnt));
            check($sformatf("vec%0d.idx", i),   32'(ifA.gnt_idx),   32'(vecs[i].idx));
            check($sformatf("vec%0d.valid", i), 32'(ifA.gnt_valid), 32'(vecs[i].valid));
            check($sformatf("vec%0d.to", i),    32'(ifA.timeout),   32'(vecs[i].to));
        end

        // All clients requesting: strict rotation 0..15 then back to 0.
        applyStimulus(16'h0000, 1'b0, 1'b1);
        applyStimulus(16'hFFFF, 1'b0, 1'b0);
        for (int g = 0; g <= 16; g++) begin
            check("rr.idx",   32'(ifA.gnt_idx),   32'(g % 16));
            check("rr.valid", 32'(ifA.gnt_valid), 32'd1);
            applyStimulus(16'hFFFF, 1'b1, 1'b0);
            check("rr.dead",  32'(ifA.gnt_valid), 32'd0);
            applyStimulus(16'hFFFF, 1'b0, 1'b0);
        end

        // Client 15 hogs the resource: forced release after 15 cycles, then regrant.
        applyStimulus(16'h0000, 1'b0, 1'b1);
        applyStimulus(16'h8000, 1'b0, 1'b0);
        cnt   = 0;
        guard = 0;
        while (ifA.gnt_valid && guard < 40) begin
            cnt++;
            guard++;
            applyStimulus(16'h8000, 1'b0, 1'b0);
        end
        check("hog.bound", 32'(guard < 40), 32'd1);
        check("hog.len",   32'(cnt), 32'd15);
        check("hog.pulse", 32'(ifA.timeout), 32'd1);
        check("hog.gnt0",  32'(ifA.gnt), 32'd0);
        applyStimulus(16'h8000, 1'b0, 1'b0);
        check("hog.regrant", 32'(ifA.gnt), 32'h8000);
        check("hog.pulse1",  32'(ifA.timeout), 32'd0);

        // MAX_HOLD=4 instance: done on the would-be timeout edge wins.
        applyStimulus(16'h0000, 1'b0, 1'b1);
        applyStimulus(16'h0010, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(16'h0010, 1'b0, 1'b0);
        check("dwin.held", 32'(ifB.gnt), 32'h0010);
        applyStimulus(16'h0010, 1'b1, 1'b0);
        check("dwin.valid", 32'(ifB.gnt_valid), 32'd0);
        check("dwin.to",    32'(ifB.timeout),   32'd0);
        applyStimulus(16'h0010, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(16'h0010, 1'b0, 1'b0);
        applyStimulus(16'h0010, 1'b0, 1'b0);
        check("b4.to", 32'(ifB.timeout), 32'd1);
        applyStimulus(16'h0010, 1'b0, 1'b0);
        applyStimulus(16'h0000, 1'b0, 1'b0);
        check("wd.valid", 32'(ifB.gnt_valid), 32'd0);
        check("wd.to",    32'(ifB.timeout),   32'd0);

        // Reset in mid-grant clears the pointer.
        applyStimulus(16'h0000, 1'b0, 1'b1);
        applyStimulus(16'h0400, 1'b0, 1'b0);
        applyStimulus(16'h0400, 1'b1, 1'b0);
        applyStimulus(16'h0420, 1'b0, 1'b0);
        check("rst.pre", 32'(ifA.gnt_idx), 32'd5);
        applyStimulus(16'h0420, 1'b0, 1'b1);
        check("rst.gnt", 32'(ifA.gnt), 32'd0);
        check("rst.idx", 32'(ifA.gnt_idx), 32'd0);
        check("rst.to",  32'(ifA.timeout), 32'd0);
        applyStimulus(16'h0420, 1'b0, 1'b0);
        check("rst.next", 32'(ifA.gnt_idx), 32'd5);

        // Randomised traffic checked against the model on both instances.
        r = '0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0) r = 16'($urandom) & 16'($urandom);
            d  = ($urandom_range(7) == 0);
            rs = ($urandom_range(99) == 0);
            applyStimulus(r, d, rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter16.md
Name: rr_arbiter16

Overview:
- 16-requester round-robin arbiter with grant hold, done handshake and a hold-timeout watchdog.
- Shares one resource among 16 clients. The resource is selected by a 4-bit index and its one-hot enable comes from a 4-to-16 decoder.
- Outputs a registered grant index plus the decoded one-hot grant vector.
- Sits between the requesting clients and the shared-resource select logic.

Parameters:
- MAX_HOLD, 15: maximum cycles a grant may be held before forced release. 0 disables the timeout. Legal range 0..255.
- CNT_W, 8: width of the hold counter. Must hold MAX_HOLD.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req  in  16  request vector; req[k] is held high by client k until it is done.
- done  in  1  current grantee releases the resource. Sampled only in GRANT.
- gnt  out  16  one-hot grant; all zero when no grant.
- gnt_idx  out  4  index of the current/last grantee.
- gnt_valid  out  1  a grant is active.
- timeout  out  1  one-cycle pulse on a forced release.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) sets:
  - state=IDLE, ptr=0, hold_cnt=0;
  - gnt=0, gnt_idx=0, gnt_valid=0, timeout=0.
  - Reset mid-grant drops gnt the cycle after rst is sampled. No timeout pulse.
- States: IDLE, GRANT, RELEASE. All outputs are registered.
- Arbitration, evaluated in IDLE and RELEASE:
  - Winner = first k with req[k]=1, scanning ptr, ptr+1, ..., 15, 0, ..., ptr-1 (mod 16).
  - If any req is set: gnt_idx<=winner, gnt_valid<=1, hold_cnt<=0, next state GRANT.
  - Latency: req sampled at edge N gives gnt at edge N+1.
  - If no req is set: stay in (or move from RELEASE to) IDLE, gnt_valid=0.
- GRANT, at each edge with hold_cnt incrementing, release is evaluated in this priority order:
  1. done=1: normal release.
  2. req[gnt_idx]=0 (requester withdrew): normal release.
  3. MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1: forced release, timeout<=1 for exactly one cycle.
  4. Otherwise: stay in GRANT, hold_cnt<=hold_cnt+1.
- On any release:
  - gnt_valid<=0, next state RELEASE.
  - ptr<=gnt_idx+1 mod 16 (15 wraps to 0).
  - gnt_idx keeps its last value.
- done and timeout in the same cycle: done wins, timeout stays 0.
- RELEASE: gnt=0 for exactly one dead cycle, and the next arbitration happens there.
  - Minimum gap between grants is 1 cycle.
  - The same client can be regranted only if it is the sole requester.
- done outside GRANT is ignored.
- gnt = dec(gnt_idx) ANDed with {16{gnt_valid}}.
  - Decoder input bit 0 is the MSB, so the arbiter drives the decoder with bit-reversed gnt_idx.
  - Result: gnt[k]=1 exactly when gnt_idx==k.
- Invariants:
  - popcount(gnt)<=1 always.
  - gnt!=0 if and only if gnt_valid=1.
  - timeout=1 only in the cycle gnt_valid falls.

Decomposition:
- Shared package arb_pkg holds:
  - state encoding: IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2;
  - constant N_REQ=16 and IDX_W=4.
- One sub-module, rr_dec4: 4-to-16 one-hot decoder, purely combinational, input bit 0 = MSB.
- Rotate/priority search stays inline in rr_arbiter16.

Test Plan:
1. Reset, then req=16'h0000 for 5 cycles -> gnt=0, gnt_valid=0, gnt_idx=0, timeout=0 throughout.
2. req=16'h0001 at edge N, done=1 at N+3 -> gnt=16'h0001 at N+1..N+3, then 0 at N+4. ptr=1. No timeout.
3. req=16'hFFFF held, done pulsed each grant -> grant order 0,1,2,...,15,0 with one dead cycle between grants. Checks 15 to 0 wrap.
4. req=16'h8000 held with no done, MAX_HOLD=15 -> gnt=16'h8000 for exactly 15 cycles, then timeout=1 for one cycle and gnt=0. Client 15 is regranted after the dead cycle.
5. Timeout cycle with done=1 (MAX_HOLD=4, done at the 4th grant cycle) -> release, timeout stays 0. Also: req[gnt_idx] dropped with done=0 -> release next edge, no timeout.
6. Grant active on client 5 with req=16'h0420, rst=1 for one cycle -> gnt=0 and ptr=0 after reset. Next grant goes to client 5 (lowest from 0), not client 10.
